// File: rtl/ras_fifo_v2_if.sv
// Handshake/data bundle between the RAS spill producer, the spill FIFO and the refill consumer.
// Parity outputs are present only when RAS_FIFO_V2_PARITY_EN is defined.
interface ras_fifo_v2_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 36
);
    localparam int ADDR = $clog2(DEPTH);

    logic              flush;
    logic              push;
    logic [WIDTH-1:0]  din;
    logic              pop;
    logic              err_clr;
    logic [WIDTH-1:0]  dout;
    logic              empty;
    logic              full;
    logic              afull;
    logic [ADDR:0]     count;
    logic              ovf_err;
    logic              unf_err;
`ifdef RAS_FIFO_V2_PARITY_EN
    logic              par_err;
    logic              par_err_sticky;
`endif

    modport master (
        output flush, push, din, pop, err_clr,
        input  dout, empty, full, afull, count, ovf_err, unf_err
`ifdef RAS_FIFO_V2_PARITY_EN
        , input par_err, par_err_sticky
`endif
    );

    modport slave (
        input  flush, push, din, pop, err_clr,
        output dout, empty, full, afull, count, ovf_err, unf_err
`ifdef RAS_FIFO_V2_PARITY_EN
        , output par_err, par_err_sticky
`endif
    );
endinterface

// File: rtl/ras_fifo_v2.sv
// RAS spill FIFO, first-word-fall-through; 1-cycle push-to-dout latency when empty, 0-cycle pop.
// Backpressure: full drops a lone push (sticky ovf_err); push+pop at full both proceed. Optional: RAS_FIFO_V2_PARITY_EN.
module ras_fifo_v2 #(
    parameter int DEPTH        = 1024,
    parameter int WIDTH        = 36,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic         clk,
    input  logic         rst,
    ras_fifo_v2_if.slave bus
);
    localparam int ADDR = $clog2(DEPTH);
`ifdef RAS_FIFO_V2_PARITY_EN
    localparam int MW = WIDTH + 1;
`else
    localparam int MW = WIDTH;
`endif
    localparam logic [ADDR:0] ONE     = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR:0] AFULL_C = AFULL_THRESH[ADDR:0];

    logic [MW-1:0] mem [DEPTH];

    logic [ADDR:0] rptr_q, rptr_d;
    logic [ADDR:0] wptr_q, wptr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [ADDR:0] cnt;
    logic          empty, full, afull;
    logic          push_ok, pop_ok;
    logic          ovf_set, unf_set;
    logic [MW-1:0] wr_word, rd_word;
`ifdef RAS_FIFO_V2_PARITY_EN
    logic          par_err;
    logic          par_q, par_d;
`endif

    always_comb begin
        cnt     = wptr_q - rptr_q;
        empty   = (rptr_q == wptr_q);
        full    = (rptr_q[ADDR-1:0] == wptr_q[ADDR-1:0]) && (rptr_q[ADDR] != wptr_q[ADDR]);
        afull   = (cnt >= AFULL_C);
        // flush suppresses both accepts and any error reporting in its cycle
        push_ok = bus.push & (!full | bus.pop) & !bus.flush;
        pop_ok  = bus.pop & !empty & !bus.flush;
        ovf_set = bus.push & full & !bus.pop & !bus.flush;
        unf_set = bus.pop & empty & !bus.flush;
        rd_word = mem[rptr_q[ADDR-1:0]];
`ifdef RAS_FIFO_V2_PARITY_EN
        wr_word = {^bus.din, bus.din};
        par_err = !empty && (rd_word[WIDTH] != ^rd_word[WIDTH-1:0]);
        par_d   = (par_q & !bus.err_clr) | (par_err & pop_ok);
`else
        wr_word = bus.din;
`endif
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        if (bus.flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + ONE;
            if (pop_ok)  rptr_d = rptr_q + ONE;
        end
        // a new error in the same cycle as err_clr still sets the flag
        ovf_d = (ovf_q & !bus.err_clr) | ovf_set;
        unf_d = (unf_q & !bus.err_clr) | unf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
`ifdef RAS_FIFO_V2_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
`ifdef RAS_FIFO_V2_PARITY_EN
            par_q  <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[ADDR-1:0]] <= wr_word;
    end

    assign bus.dout    = rd_word[WIDTH-1:0];
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.afull   = afull;
    assign bus.count   = cnt;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
`ifdef RAS_FIFO_V2_PARITY_EN
    assign bus.par_err        = par_err;
    assign bus.par_err_sticky = par_q;
`endif
endmodule

// File: tb/tb_ras_fifo_v2.sv
// Directed bench for ras_fifo_v2 at DEPTH=8, WIDTH=8, AFULL_THRESH=6.
module tb_ras_fifo_v2;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    ras_fifo_v2_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    ras_fifo_v2 #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THRESH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        idle();
        bus.din = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst_empty", bus.empty, 1);
        chk("rst_full",  bus.full,  0);
        chk("rst_afull", bus.afull, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ovf",   bus.ovf_err, 0);
        chk("rst_unf",   bus.unf_err, 0);
        #9 rst = 1'b0;

        // basic push / pop ordering
        bus.push = 1; bus.din = 8'h11; step();
        chk("t1_cnt1", bus.count, 1); chk("t1_empty", bus.empty, 0); chk("t1_dout", bus.dout, 8'h11);
        bus.din = 8'h22; step(); chk("t1_cnt2", bus.count, 2);
        bus.din = 8'h33; step(); chk("t1_cnt3", bus.count, 3); chk("t1_head", bus.dout, 8'h11);
        bus.push = 0; bus.pop = 1; step();
        chk("t1_pop1", bus.dout, 8'h22);
        step(); chk("t1_pop2", bus.dout, 8'h33);
        step(); chk("t1_empty_end", bus.empty, 1); chk("t1_cnt_end", bus.count, 0);
        idle();

        // fill to full, overflow, drain
        for (int i = 1; i <= 8; i++) begin
            bus.push = 1; bus.din = 8'(i); step();
            chk("t2_cnt", bus.count, 32'(i));
            if (i == 5) chk("t2_afull5", bus.afull, 0);
            if (i == 6) chk("t2_afull6", bus.afull, 1);
            if (i == 7) chk("t2_full7", bus.full, 0);
        end
        chk("t2_full", bus.full, 1);
        bus.din = 8'h99; step();
        chk("t2_ovf", bus.ovf_err, 1); chk("t2_ovf_cnt", bus.count, 8); chk("t2_unf", bus.unf_err, 0);
        bus.push = 0; bus.pop = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("t2_drain", bus.dout, 32'(i));
            step();
        end
        chk("t2_drained", bus.empty, 1);
        idle(); bus.err_clr = 1; step(); idle();
        chk("t2_ovf_clr", bus.ovf_err, 0);

        // push + pop at full
        for (int i = 1; i <= 8; i++) begin
            bus.push = 1; bus.din = 8'(8'h20 + i); step();
        end
        bus.din = 8'hAA; bus.pop = 1; step();
        chk("t3_cnt", bus.count, 8); chk("t3_full", bus.full, 1);
        chk("t3_head", bus.dout, 8'h22); chk("t3_ovf", bus.ovf_err, 0);
        bus.push = 0;
        for (int i = 2; i <= 8; i++) begin
            chk("t3_drain", bus.dout, 32'(8'h20 + i));
            step();
        end
        chk("t3_aa", bus.dout, 8'hAA); chk("t3_cnt1", bus.count, 1);
        step(); chk("t3_empty", bus.empty, 1);
        idle();

        // push + pop at empty
        bus.push = 1; bus.pop = 1; bus.din = 8'h5A; step();
        chk("t4_unf", bus.unf_err, 1); chk("t4_cnt", bus.count, 1); chk("t4_dout", bus.dout, 8'h5A);
        idle(); bus.err_clr = 1; step();
        chk("t4_unf_clr", bus.unf_err, 0);
        idle(); bus.pop = 1; step(); idle();
        chk("t4_empty", bus.empty, 1);

        // err_clr with a simultaneous underflow: set wins
        bus.pop = 1; bus.err_clr = 1; step(); idle();
        chk("t4_set_wins", bus.unf_err, 1);
        bus.err_clr = 1; step(); idle();

        // streaming with wrap, then flush
        for (int i = 0; i < 5; i++) begin
            bus.push = 1; bus.din = 8'(i); step();
        end
        bus.pop = 1;
        for (int i = 0; i < 20; i++) begin
            chk("t5_head", bus.dout, 32'(i));
            bus.din = 8'(i + 5); step();
            chk("t5_cnt", bus.count, 5);
        end
        chk("t5_head_end", bus.dout, 20);
        bus.flush = 1; bus.din = 8'hEE; step();
        chk("t5_fl_empty", bus.empty, 1); chk("t5_fl_cnt", bus.count, 0);
        chk("t5_fl_ovf", bus.ovf_err, 0); chk("t5_fl_unf", bus.unf_err, 0);
        step();
        chk("t5_fl_pop_empty", bus.unf_err, 0);
        idle(); bus.pop = 1; step(); idle();
        chk("t5_unf", bus.unf_err, 1);
        bus.flush = 1; step(); idle();
        chk("t5_flush_keeps_unf", bus.unf_err, 1);
        bus.err_clr = 1; step(); idle();

        // asynchronous reset mid-burst
        bus.push = 1;
        for (int i = 0; i < 3; i++) begin
            bus.din = 8'(8'h40 + i); step();
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_empty", bus.empty, 1); chk("t6_cnt", bus.count, 0); chk("t6_full", bus.full, 0);
        bus.push = 0;
        #2 rst = 1'b0;
        step();
        chk("t6_still_empty", bus.empty, 1);

`ifdef RAS_FIFO_V2_PARITY_EN
        bus.push = 1; bus.din = 8'h3C; step(); idle();
        chk("t7_par_ok", bus.par_err, 0);
        dut.mem[0][WIDTH] = ~dut.mem[0][WIDTH];
        #1;
        chk("t7_par_err", bus.par_err, 1);
        bus.pop = 1; step(); idle();
        chk("t7_par_sticky", bus.par_err_sticky, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
